// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and framing constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_STOP_BITS       = 1;
    localparam int UART_CLK_DIV_DEFAULT = 868;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with registered full/empty/count
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // Flags are registered so a consumer's pop never ripples into push acceptance.
    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - 8N1 UART transmitter fed from a ready/valid byte stream
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          io_enable,
    input  logic                          io_enq_valid,
    output logic                          io_enq_ready,
    input  logic [7:0]                    io_enq_bits,
    output logic                          io_txd,
    output logic                          io_busy,
    output logic [$clog2(FIFO_DEPTH):0]   io_count
);

    localparam int              BW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;

    logic        pop;
    logic        baud_end;
    logic        can_start;
    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (io_enq_valid),
        .push_data (io_enq_bits),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (io_count)
    );

    assign baud_end  = (baud_q == BAUD_LAST);
    assign can_start = !fifo_empty && io_enable;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // Chaining straight into START keeps consecutive frames gap-free.
                    if (can_start) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign io_txd       = txd_q;
    assign io_busy      = busy_q;
    assign io_enq_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - scoreboard bench decoding frames off io_txd
module tb_uart_tx_stream;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_enable = 1'b0;
    logic       io_enq_valid = 1'b0;
    logic [7:0] io_enq_bits = 8'h00;
    logic       io_enq_ready;
    logic       io_txd;
    logic       io_busy;
    logic [2:0] io_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];

    int         cyc = 0;
    bit         in_frame = 1'b0;
    int         fcyc = 0;
    logic [9:0] fbits = '0;
    int         frames_done = 0;
    int         last_end = 0;
    bit         gap_on = 1'b0;
    int         gap_base = 0;
    int         nf = 0;

    uart_tx_stream #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_enable    (io_enable),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_enq_bits  (io_enq_bits),
        .io_txd       (io_txd),
        .io_busy      (io_busy),
        .io_count     (io_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line monitor: every cycle of a frame is compared against the scoreboard byte.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && io_txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    fbits = '0;
                end else begin
                    fbits = {1'b1, exp_q.pop_front(), 1'b0};
                end
                if (gap_on && frames_done > gap_base) begin
                    check("no_gap", cyc, last_end + 1);
                end
                in_frame = 1'b1;
                fcyc = 0;
            end
            if (in_frame) begin
                check("frame_bit", io_txd, fbits[fcyc / CLK_DIV]);
                check("frame_busy", io_busy, 1'b1);
                fcyc++;
                if (fcyc == FRAME) begin
                    in_frame = 1'b0;
                    frames_done++;
                    last_end = cyc;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        io_enq_valid = 1'b1;
        io_enq_bits  = b;
        while (io_enq_ready !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("push_ready_wait", (n < 500), 1);
        @(posedge clock);
        exp_q.push_back(b);
        @(negedge clock);
        io_enq_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("frames_done", frames_done, n);
    endtask

    task automatic wait_fcyc(input int c);
        int k = 0;
        while (!(in_frame && fcyc >= c) && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("reach_frame_cycle", (k < 500), 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;

        repeat (50) begin
            @(negedge clock);
            check("idle_outputs", {io_txd, io_busy, io_enq_ready, io_count}, {1'b1, 1'b0, 1'b1, 3'd0});
        end

        io_enable = 1'b1;
        push(8'h01);
        check("latency_pre_txd", io_txd, 1'b1);
        check("count_after_push", io_count, 3'd1);
        @(posedge clock);
        #1;
        check("latency_txd_low", io_txd, 1'b0);
        check("busy_at_start", io_busy, 1'b1);
        check("count_after_pop", io_count, 3'd0);
        wait_frames(1);
        @(negedge clock);
        check("busy_after_frame", io_busy, 1'b0);
        check("txd_after_frame", io_txd, 1'b1);

        io_enable = 1'b0;
        gap_base = frames_done;
        gap_on = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push(8'(i));
        end
        check("full_count", io_count, 3'd4);
        check("full_ready", io_enq_ready, 1'b0);
        io_enable = 1'b1;
        push(8'h05);
        wait_frames(gap_base + 5);
        gap_on = 1'b0;
        @(negedge clock);
        check("b2b_busy_end", io_busy, 1'b0);
        check("b2b_count_end", io_count, 3'd0);
        check("b2b_queue_drained", exp_q.size(), 0);

        io_enable = 1'b0;
        push(8'hA5);
        nf = frames_done;
        repeat (100) @(negedge clock);
        check("disabled_txd", io_txd, 1'b1);
        check("disabled_count", io_count, 3'd1);
        check("disabled_no_frame", frames_done, nf);
        io_enable = 1'b1;
        wait_frames(nf + 1);

        nf = frames_done;
        push(8'hFF);
        push(8'h55);
        wait_fcyc(4 + 3 * CLK_DIV + 1);
        io_enable = 1'b0;
        wait_frames(nf + 1);
        @(negedge clock);
        check("stop_busy", io_busy, 1'b0);
        check("stop_count", io_count, 3'd1);
        check("stop_txd", io_txd, 1'b1);
        repeat (50) @(negedge clock);
        check("stop_no_next_frame", frames_done, nf + 1);
        io_enable = 1'b1;
        wait_frames(nf + 2);

        push(8'h3C);
        push(8'h11);
        push(8'h22);
        wait_fcyc(2 * CLK_DIV + 2);
        check("pre_reset_count", io_count, 3'd2);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("reset_txd", io_txd, 1'b1);
        check("reset_busy", io_busy, 1'b0);
        check("reset_count", io_count, 3'd0);
        check("reset_ready", io_enq_ready, 1'b1);
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        nf = frames_done;
        repeat (60) @(negedge clock);
        check("post_reset_no_frame", frames_done, nf);
        check("post_reset_txd", io_txd, 1'b1);
        push(8'h5A);
        wait_frames(nf + 1);
        @(negedge clock);
        check("final_busy", io_busy, 1'b0);
        check("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        check("watchdog", 32'd0, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
